// File: rtl/debug_unit_pkg.sv
// Shared constants for the UART debug controller: command bytes, FSM encoding, dump size.
package debug_unit_pkg;

  localparam logic [7:0] CMD_LOAD = 8'h4C;
  localparam logic [7:0] CMD_CONT = 8'h43;
  localparam logic [7:0] CMD_STEP = 8'h53;
  localparam logic [7:0] CMD_NEXT = 8'h4E;
  localparam logic [7:0] CMD_EXIT = 8'h45;

  localparam int DUMP_BYTES = 264;

  typedef enum logic [3:0] {
    ST_IDLE       = 4'd0,
    ST_LOAD_CNT   = 4'd1,
    ST_LOAD_BYTE  = 4'd2,
    ST_LOAD_WRITE = 4'd3,
    ST_RUN        = 4'd4,
    ST_STEP_WAIT  = 4'd5,
    ST_STEP_EXEC  = 4'd6,
    ST_DUMP_FETCH = 4'd7,
    ST_DUMP_LATCH = 4'd8,
    ST_DUMP_SEND  = 4'd9,
    ST_DUMP_WAIT  = 4'd10
  } state_e;

endpackage

// File: rtl/debug_tx_serializer.sv
// Splits a 32-bit word into 4 UART bytes, MSB first; one tx_start per byte,
// next byte only after tx_done, then a one-cycle done_o pulse. Starts ignored while busy.
module debug_tx_serializer (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start_i,
  input  logic [31:0] word_i,
  input  logic        tx_done_i,
  output logic        tx_start_o,
  output logic [7:0]  tx_data_o,
  output logic        done_o
);

  logic        busy_q;
  logic [23:0] sh_q;
  logic [1:0]  cnt_q;
  logic        start_q;
  logic [7:0]  data_q;
  logic        done_q;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      busy_q  <= 1'b0;
      sh_q    <= '0;
      cnt_q   <= '0;
      start_q <= 1'b0;
      data_q  <= '0;
      done_q  <= 1'b0;
    end else begin
      start_q <= 1'b0;
      done_q  <= 1'b0;
      if (start_i && !busy_q) begin
        busy_q  <= 1'b1;
        data_q  <= word_i[31:24];
        sh_q    <= word_i[23:0];
        cnt_q   <= '0;
        start_q <= 1'b1;
      end else if (busy_q && tx_done_i) begin
        if (cnt_q == 2'd3) begin
          busy_q <= 1'b0;
          done_q <= 1'b1;
        end else begin
          cnt_q   <= cnt_q + 2'd1;
          data_q  <= sh_q[23:16];
          sh_q    <= {sh_q[15:0], 8'h00};
          start_q <= 1'b1;
        end
      end
    end
  end

  assign tx_start_o = start_q;
  assign tx_data_o  = data_q;
  assign done_o     = done_q;

endmodule

// File: rtl/debug_unit.sv
// UART debug controller: loads instruction memory, runs/steps the MIPS core and
// dumps PC, cycle count, registers and data memory; TX paced by i_tx_done.
module debug_unit
  import debug_unit_pkg::*;
#(
  parameter int IMEM_ADDR_W  = 8,
  parameter int N_DMEM_WORDS = 32,
  parameter int DMEM_ADDR_W  = 5
) (
  input  logic                   CLK100MHZ,
  input  logic                   SWITCH_RESET,
  input  logic                   i_rx_done,
  input  logic [7:0]             i_rx_data,
  output logic                   o_tx_start,
  output logic [7:0]             o_tx_data,
  input  logic                   i_tx_done,
  output logic                   o_imem_we,
  output logic [IMEM_ADDR_W-1:0] o_imem_addr,
  output logic [31:0]            o_imem_wdata,
  output logic                   o_cpu_rst_n,
  output logic                   o_cpu_en,
  input  logic                   i_halt,
  input  logic [31:0]            i_pc,
  output logic [4:0]             o_dbg_reg_addr,
  input  logic [31:0]            i_dbg_reg_data,
  output logic [DMEM_ADDR_W-1:0] o_dbg_mem_addr,
  input  logic [31:0]            i_dbg_mem_data,
  output logic [3:0]             o_state
);

  localparam int DumpWords = 34 + N_DMEM_WORDS;

  state_e                 state_q, state_d;
  logic                   step_q, rst_n_q;
  logic [1:0]             bcnt_q;
  logic [31:0]            acc_q, cyc_q, pc_q, word_q, word_sel;
  logic [8:0]             left_q;
  logic [IMEM_ADDR_W-1:0] widx_q;
  logic [6:0]             didx_q;
  logic [4:0]             idx_off;
  logic                   ser_start, ser_done, dump_last;

  assign dump_last = (didx_q == 7'(DumpWords - 1));

  always_ff @(posedge CLK100MHZ) begin
    if (!SWITCH_RESET) state_q <= ST_IDLE;
    else               state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE: if (i_rx_done) begin
        case (i_rx_data)
          CMD_LOAD: state_d = ST_LOAD_CNT;
          CMD_CONT: state_d = ST_RUN;
          CMD_STEP: state_d = ST_STEP_WAIT;
          default:  state_d = ST_IDLE;
        endcase
      end
      ST_LOAD_CNT:   if (i_rx_done) state_d = ST_LOAD_BYTE;
      ST_LOAD_BYTE:  if (i_rx_done && bcnt_q == 2'd3) state_d = ST_LOAD_WRITE;
      ST_LOAD_WRITE: state_d = (left_q == 9'd1) ? ST_IDLE : ST_LOAD_BYTE;
      ST_RUN:        if (i_halt) state_d = ST_DUMP_FETCH;
      ST_STEP_WAIT: if (i_rx_done) begin
        if (i_rx_data == CMD_NEXT)      state_d = ST_STEP_EXEC;
        else if (i_rx_data == CMD_EXIT) state_d = ST_IDLE;
      end
      ST_STEP_EXEC:  state_d = ST_DUMP_FETCH;
      ST_DUMP_FETCH: state_d = ST_DUMP_LATCH;
      ST_DUMP_LATCH: state_d = ST_DUMP_SEND;
      ST_DUMP_SEND:  state_d = ST_DUMP_WAIT;
      ST_DUMP_WAIT: if (ser_done) begin
        if (!dump_last)             state_d = ST_DUMP_FETCH;
        else if (step_q && !i_halt) state_d = ST_STEP_WAIT;
        else                        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    o_cpu_en  = 1'b0;
    o_imem_we = 1'b0;
    ser_start = 1'b0;
    case (state_q)
      ST_RUN, ST_STEP_EXEC: o_cpu_en  = 1'b1;
      ST_LOAD_WRITE:        o_imem_we = 1'b1;
      ST_DUMP_SEND:         ser_start = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge CLK100MHZ) begin
    if (!SWITCH_RESET) begin
      step_q  <= 1'b0;
      rst_n_q <= 1'b0;
      bcnt_q  <= '0;
      acc_q   <= '0;
      cyc_q   <= '0;
      pc_q    <= '0;
      word_q  <= '0;
      left_q  <= '0;
      widx_q  <= '0;
      didx_q  <= '0;
    end else begin
      case (state_q)
        ST_IDLE: if (i_rx_done) begin
          if (i_rx_data == CMD_LOAD) rst_n_q <= 1'b0;
          if (i_rx_data == CMD_STEP) step_q  <= 1'b1;
        end
        ST_LOAD_CNT: if (i_rx_done) begin
          left_q <= {i_rx_data == 8'd0, i_rx_data};
          widx_q <= '0;
          bcnt_q <= '0;
          cyc_q  <= '0;
        end
        ST_LOAD_BYTE: if (i_rx_done) begin
          acc_q  <= {acc_q[23:0], i_rx_data};
          bcnt_q <= bcnt_q + 2'd1;
        end
        ST_LOAD_WRITE: begin
          widx_q <= widx_q + IMEM_ADDR_W'(1);
          left_q <= left_q - 9'd1;
          if (left_q == 9'd1) rst_n_q <= 1'b1;
        end
        ST_RUN, ST_STEP_EXEC: cyc_q <= cyc_q + 32'd1;
        ST_STEP_WAIT: if (i_rx_done && i_rx_data == CMD_EXIT) step_q <= 1'b0;
        ST_DUMP_FETCH: if (didx_q == 7'd0) pc_q <= i_pc;
        ST_DUMP_LATCH: word_q <= word_sel;
        ST_DUMP_WAIT: if (ser_done) begin
          if (dump_last) begin
            didx_q <= '0;
            if (!(step_q && !i_halt)) step_q <= 1'b0;
          end else begin
            didx_q <= didx_q + 7'd1;
          end
        end
        default: ;
      endcase
    end
  end

  // Register words sit at dump index 2..33 and memory at 34..; both map to (index-2) mod 32.
  assign idx_off        = didx_q[4:0] - 5'd2;
  assign o_dbg_reg_addr = (didx_q >= 7'd2 && didx_q < 7'd34) ? idx_off : '0;
  assign o_dbg_mem_addr = (didx_q >= 7'd34) ? DMEM_ADDR_W'(idx_off) : '0;

  always_comb begin
    word_sel = i_dbg_mem_data;
    if (didx_q == 7'd0)      word_sel = pc_q;
    else if (didx_q == 7'd1) word_sel = cyc_q;
    else if (didx_q < 7'd34) word_sel = i_dbg_reg_data;
  end

  debug_tx_serializer u_ser (
    .clk        (CLK100MHZ),
    .rst_n      (SWITCH_RESET),
    .start_i    (ser_start),
    .word_i     (word_q),
    .tx_done_i  (i_tx_done),
    .tx_start_o (o_tx_start),
    .tx_data_o  (o_tx_data),
    .done_o     (ser_done)
  );

  assign o_imem_addr  = widx_q;
  assign o_imem_wdata = acc_q;
  assign o_cpu_rst_n  = rst_n_q;
  assign o_state      = state_q;

endmodule

// File: doc/debug_unit.md
Name: debug_unit

Overview:
- UART-driven controller that sequences the MIPS core on the Nexys3 board.
- Loads a program into instruction memory from host bytes and runs the core in continuous or single-step mode.
- After each run or step, dumps PC, cycle count, register file and data memory back to the host.
- Sits in TOP between the UART RX/TX modules and the MIPS datapath's control and debug ports.

Parameters:
- IMEM_ADDR_W, 8, instruction memory word-address width.
- N_DMEM_WORDS, 32, data memory words dumped, addresses 0..N-1.
- DMEM_ADDR_W, 5, data memory debug word-address width.
- CMD_LOAD, 8'h4C ('L'), load-program command.
- CMD_CONT, 8'h43 ('C'), continuous-run command.
- CMD_STEP, 8'h53 ('S'), enter step mode.
- CMD_NEXT, 8'h4E ('N'), execute one cycle (step mode only).
- CMD_EXIT, 8'h45 ('E'), leave step mode.

Ports:
- CLK100MHZ  in  1  system clock.
- SWITCH_RESET  in  1  synchronous, active-low reset.
- i_rx_done  in  1  one-cycle pulse: i_rx_data valid.
- i_rx_data  in  8  received byte.
- o_tx_start  out  1  one-cycle pulse: send o_tx_data.
- o_tx_data  out  8  byte to transmit, held until i_tx_done.
- i_tx_done  in  1  one-cycle pulse: byte transmission finished.
- o_imem_we  out  1  instruction memory write strobe.
- o_imem_addr  out  IMEM_ADDR_W  instruction word address.
- o_imem_wdata  out  32  instruction word.
- o_cpu_rst_n  out  1  active-low core reset.
- o_cpu_en  out  1  core clock enable (pipeline advances when 1).
- i_halt  in  1  halt instruction has reached WB.
- i_pc  in  32  current PC.
- o_dbg_reg_addr  out  5  register file debug read address.
- i_dbg_reg_data  in  32  register data, 1-cycle registered read.
- o_dbg_mem_addr  out  DMEM_ADDR_W  data memory debug read address.
- i_dbg_mem_data  in  32  memory data, 1-cycle registered read.
- o_state  out  4  current state encoding, for LEDs.

Behaviour:
- Reset (SWITCH_RESET=0 at clock edge):
  - State IDLE; all strobes 0; o_cpu_en=0; o_cpu_rst_n=0.
  - All addresses 0; o_tx_data=0; cycle counter 0.
  - Reset mid-operation aborts immediately; a half-loaded word is discarded.
- o_cpu_rst_n: 0 from reset until the first load completes, 0 again throughout any LOAD. Otherwise 1.
- IDLE: decode bytes on i_rx_done.
  - 'L' -> LOAD_CNT.
  - 'C' -> RUN.
  - 'S' -> STEP_WAIT.
  - Any other byte is ignored.
- LOAD_CNT: next byte is the word count N (0 means 256); clear the cycle counter; go to LOAD_BYTE.
- LOAD_BYTE: bytes are accumulated MSB first.
- LOAD_WRITE: after the 4th byte, o_imem_we=1 for exactly one cycle with o_imem_addr = word index (from 0); the index increments afterwards.
  - After N words -> IDLE with o_cpu_rst_n=1.
  - Words beyond 2^IMEM_ADDR_W wrap the address.
- RUN: o_cpu_en=1 each cycle; cycle counter +1 per cycle with o_cpu_en=1.
  - When i_halt=1 is sampled, o_cpu_en=0 from the next cycle -> DUMP.
  - RX bytes are ignored in RUN.
- STEP_WAIT: o_cpu_en=0.
  - 'N' -> STEP_EXEC.
  - 'E' -> IDLE.
  - Other bytes are ignored.
- STEP_EXEC: o_cpu_en=1 for exactly one cycle, counter +1 -> DUMP.
- DUMP: sends 264 bytes, each 32-bit value MSB first, in this order:
  - PC snapshot, taken on DUMP entry.
  - Cycle count.
  - R0..R31.
  - DMEM[0..N_DMEM_WORDS-1].
- Dump sequencing:
  - Each register/memory word: drive the address, wait 1 cycle, latch data, then send 4 bytes.
  - Per byte: one-cycle o_tx_start, then wait for i_tx_done before the next byte.
  - RX bytes during DUMP are ignored.
- DUMP completion:
  - Step mode with i_halt=0 -> STEP_WAIT.
  - Otherwise -> IDLE.
- Halt already asserted on entry to RUN: exactly 1 enabled cycle, then dump.
- Cycle counter is 32 bits and wraps at 2^32.
- Simultaneous i_rx_done and i_tx_done: both honoured per the current state.

Decomposition:
- Shared package holds:
  - command byte constants;
  - state encoding (IDLE=0, LOAD_CNT, LOAD_BYTE, LOAD_WRITE, RUN, STEP_WAIT, STEP_EXEC, DUMP_FETCH, DUMP_LATCH, DUMP_SEND, DUMP_WAIT);
  - DUMP_BYTES=264.
- One natural sub-module, debug_tx_serializer: takes a 32-bit word plus a start pulse, emits 4 UART bytes MSB first, pulses done.

Test Plan:
- Reset held 0 for 3 cycles mid-LOAD -> all outputs at reset values, state IDLE, no imem write.
- Send 'L', 0x02, 20 01 00 05, FC 00 00 00 -> two o_imem_we pulses: addr 0 data 0x20010005, addr 1 data 0xFC000000; o_cpu_rst_n rises after the 2nd write.
- 'C' with i_halt asserted after 7 enabled cycles -> o_cpu_en high exactly 7 cycles; first 8 TX bytes are the PC, then 00 00 00 07; 264 bytes total.
- 'S', 'N', 'N' -> two single-cycle o_cpu_en pulses, two 264-byte dumps with counts 1 and 2; 'E' -> IDLE.
- Model reg R5=0xDEADBEEF with 1-cycle read -> dump bytes 28..31 (0-based, 4 bytes per value) = DE AD BE EF; send 'X' and 'N' in IDLE -> ignored, no TX.
- Delay i_tx_done by 100 cycles per byte -> o_tx_start never re-pulses before i_tx_done; no bytes lost.
